// File: rtl/mc_ctrl_fsm_hs.sv
// Multicycle controller for the MIPS-like core: decodes op/funct into a 22-bit control word,
// handles memory wait states, bus timeouts, illegal-instruction and irq traps, and keeps counters.
module mc_ctrl_fsm_hs #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int IRQ_EN      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op_in,
    input  logic [5:0]       funct_in,
    input  logic             alu_zero,
    input  logic             mem_ready,
    input  logic             irq,
    output logic [3:0]       state,
    output logic [21:0]      ctrl_out,
    output logic             mem_req,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             epc_write,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_ADDR  = 4'd2,  S_MEMRD = 4'd3;
    localparam logic [3:0] S_WBLD   = 4'd4,  S_BRANCH = 4'd5,  S_MEMWR = 4'd6,  S_EXEC  = 4'd7;
    localparam logic [3:0] S_WBALU  = 4'd8,  S_SHXOR  = 4'd9,  S_DX1   = 4'd10, S_DX2   = 4'd11;
    localparam logic [3:0] S_DXWB   = 4'd12, S_TRAP   = 4'd13;

    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100001, F_AND = 6'b100100, F_OR = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110, F_NOR = 6'b100111, F_ROT = 6'b000000, F_SLL = 6'b000001;
    localparam logic [5:0] F_SRL = 6'b000010, F_SRA = 6'b000011, F_JR = 6'b001000, F_SYS = 6'b001100;
    localparam logic [5:0] F_SLXOR = 6'b101001, F_SRXOR = 6'b101010, F_DXOR = 6'b110010, F_SLT = 6'b111000;

    localparam logic [5:0] OP_R    = 6'b000000, OP_ADDI = 6'b001000, OP_SUBI = 6'b001001, OP_SLTI = 6'b001011;
    localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110, OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // Wait counter only needs to reach MEM_TIMEOUT-1; it saturates when the timeout is disabled.
    localparam int              WC_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [WC_W-1:0] WC_MAX   = '1;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [1:0]       w_cause;
    logic [WC_W-1:0]  r_wait;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_stall;

    logic w_f_arith, w_f_logic, w_f_shift, w_f_rot, w_f_shx, w_f_slt, w_f_jr, w_f_sys, w_f_dx, w_f_legal;
    logic w_o_arith, w_o_logic, w_o_slti, w_o_lw, w_o_sw, w_o_beq, w_o_bne, w_o_j, w_o_jal, w_o_legal;
    logic w_is_r, w_illegal, w_jr, w_sys, w_dx, w_shx, w_branch;
    logic w_irq_take, w_mem_wait, w_timeout;

    always_comb begin : decode_funct
        w_f_arith = 1'b0; w_f_logic = 1'b0; w_f_shift = 1'b0; w_f_rot = 1'b0; w_f_shx = 1'b0;
        w_f_slt   = 1'b0; w_f_jr    = 1'b0; w_f_sys   = 1'b0; w_f_dx  = 1'b0;
        case (funct_in)
            F_ADD, F_SUB:                w_f_arith = 1'b1;
            F_AND, F_OR, F_XOR, F_NOR:   w_f_logic = 1'b1;
            F_ROT:                       w_f_rot   = 1'b1;
            F_SLL, F_SRL, F_SRA:         w_f_shift = 1'b1;
            F_SLXOR, F_SRXOR:            w_f_shx   = 1'b1;
            F_SLT:                       w_f_slt   = 1'b1;
            F_JR:                        w_f_jr    = 1'b1;
            F_SYS:                       w_f_sys   = 1'b1;
            F_DXOR:                      w_f_dx    = 1'b1;
            default: ;
        endcase
        w_f_legal = w_f_arith | w_f_logic | w_f_rot | w_f_shift | w_f_shx | w_f_slt | w_f_jr | w_f_sys | w_f_dx;
    end

    always_comb begin : decode_op
        w_o_arith = 1'b0; w_o_logic = 1'b0; w_o_slti = 1'b0; w_o_lw = 1'b0; w_o_sw = 1'b0;
        w_o_beq   = 1'b0; w_o_bne   = 1'b0; w_o_j    = 1'b0; w_o_jal = 1'b0;
        case (op_in)
            OP_ADDI, OP_SUBI:          w_o_arith = 1'b1;
            OP_ANDI, OP_ORI, OP_XORI:  w_o_logic = 1'b1;
            OP_SLTI:                   w_o_slti  = 1'b1;
            OP_LW:                     w_o_lw    = 1'b1;
            OP_SW:                     w_o_sw    = 1'b1;
            OP_BEQ:                    w_o_beq   = 1'b1;
            OP_BNE:                    w_o_bne   = 1'b1;
            OP_J:                      w_o_j     = 1'b1;
            OP_JAL:                    w_o_jal   = 1'b1;
            default: ;
        endcase
        w_o_legal = w_o_arith | w_o_logic | w_o_slti | w_o_lw | w_o_sw | w_o_beq | w_o_bne | w_o_j | w_o_jal;
    end

    assign w_is_r    = (op_in == OP_R);
    assign w_illegal = w_is_r ? !w_f_legal : !w_o_legal;
    assign w_jr      = w_is_r & w_f_jr;
    assign w_sys     = w_is_r & w_f_sys;
    assign w_dx      = w_is_r & w_f_dx;
    assign w_shx     = w_is_r & w_f_shx;
    assign w_branch  = w_jr | w_sys | w_o_beq | w_o_bne;

    // An irq is only taken on the first FETCH cycle, before memory is requested.
    assign w_irq_take = (IRQ_EN != 0) && irq && (r_state == S_FETCH) && (r_wait == '0);
    assign w_mem_wait = mem_req && !mem_ready;
    assign w_timeout  = (MEM_TIMEOUT > 0) && w_mem_wait && (r_wait == WC_LIMIT);

    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin : next_state
        w_next  = r_state;
        w_cause = 2'b00;
        case (r_state)
            S_FETCH: begin
                if (w_irq_take)     begin w_next = S_TRAP; w_cause = 2'b11; end
                else if (mem_ready) w_next = S_DECODE;
                else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b10; end
            end
            S_DECODE: begin
                if (w_illegal)                begin w_next = S_TRAP; w_cause = 2'b01; end
                else if (w_o_j || w_o_jal)    w_next = S_FETCH;
                else if (w_dx)                w_next = S_DX1;
                else if (w_o_lw || w_o_sw)    w_next = S_ADDR;
                else if (w_branch)            w_next = S_BRANCH;
                else                          w_next = S_EXEC;
            end
            S_ADDR:   w_next = w_o_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)      w_next = S_WBLD;
                else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b10; end
            end
            S_MEMWR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) begin w_next = S_TRAP; w_cause = 2'b10; end
            end
            S_EXEC:   w_next = w_shx ? S_SHXOR : S_WBALU;
            S_SHXOR:  w_next = S_WBALU;
            S_DX1:    w_next = S_DX2;
            S_DX2:    w_next = S_DXWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin : outputs
        ctrl_out  = '0;
        mem_req   = 1'b0;
        trap      = 1'b0;
        epc_write = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!w_irq_take) begin
                    ctrl_out[16]    = 1'b1;
                    ctrl_out[20:19] = 2'b11;
                    mem_req         = 1'b1;
                    if (mem_ready) begin
                        ctrl_out[14] = 1'b1;
                        ctrl_out[18] = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                ctrl_out[5:4] = 2'b11;
                if (!w_illegal && (w_o_j || w_o_jal)) ctrl_out[18] = 1'b1;
                if (!w_illegal && w_o_jal) begin
                    ctrl_out[13]    = 1'b1;
                    ctrl_out[12:11] = 2'b10;
                    ctrl_out[10]    = 1'b1;
                end
            end
            S_ADDR: begin
                ctrl_out[7:6] = 2'b01;
                ctrl_out[5:4] = 2'b10;
            end
            S_MEMRD: begin
                ctrl_out[17] = 1'b1;
                ctrl_out[16] = 1'b1;
                mem_req      = 1'b1;
            end
            S_WBLD: begin
                ctrl_out[13] = 1'b1;
                ctrl_out[16] = 1'b1;
            end
            S_MEMWR: begin
                ctrl_out[17] = 1'b1;
                ctrl_out[15] = 1'b1;
                mem_req      = 1'b1;
            end
            S_BRANCH: begin
                if (w_jr) begin
                    ctrl_out[20:19] = 2'b01;
                    ctrl_out[18]    = 1'b1;
                end else if (w_sys) begin
                    ctrl_out[21] = 1'b1;
                    ctrl_out[18] = 1'b1;
                end else begin
                    ctrl_out[20:19] = 2'b10;
                    ctrl_out[18]    = w_o_beq ? alu_zero : !alu_zero;
                end
            end
            S_EXEC: begin
                ctrl_out[7:6] = 2'b01;
                if (w_is_r) begin
                    ctrl_out[5:4] = (w_f_rot || w_f_arith || w_f_logic || w_f_slt) ? 2'b01 : 2'b10;
                    ctrl_out[3:2] = w_f_slt ? 2'b01 : funct_in[1:0];
                    if (w_f_logic)                               ctrl_out[1:0] = 2'b01;
                    else if (w_f_shift || w_f_rot || w_f_shx)    ctrl_out[1:0] = 2'b10;
                    else if (w_f_slt)                            ctrl_out[1:0] = 2'b11;
                end else begin
                    ctrl_out[5:4] = 2'b10;
                    ctrl_out[3:2] = w_o_slti ? 2'b01 : op_in[1:0];
                    if (w_o_logic)     ctrl_out[1:0] = 2'b01;
                    else if (w_o_slti) ctrl_out[1:0] = 2'b11;
                end
            end
            S_SHXOR: begin
                ctrl_out[7:6] = 2'b10;
                ctrl_out[5:4] = 2'b01;
                ctrl_out[3:2] = 2'b10;
                ctrl_out[1:0] = 2'b01;
            end
            S_WBALU: begin
                ctrl_out[13]    = 1'b1;
                ctrl_out[10]    = 1'b1;
                ctrl_out[12:11] = w_is_r ? 2'b01 : 2'b00;
            end
            S_DX1, S_DX2: begin
                ctrl_out[9:8] = 2'b11;
                ctrl_out[7:6] = 2'b01;
                ctrl_out[5:4] = 2'b01;
                ctrl_out[3:2] = 2'b10;
                ctrl_out[1:0] = 2'b01;
                if (r_state == S_DX2) begin
                    ctrl_out[13] = 1'b1;
                    ctrl_out[10] = 1'b1;
                end
            end
            S_DXWB: begin
                ctrl_out[13]    = 1'b1;
                ctrl_out[12:11] = 2'b11;
                ctrl_out[10]    = 1'b1;
            end
            S_TRAP: begin
                trap         = 1'b1;
                epc_write    = 1'b1;
                ctrl_out[21] = 1'b1;
                ctrl_out[18] = 1'b1;
            end
            default: ;
        endcase
    end

    // Wait counter restarts whenever the access completes or the FSM moves on.
    always_ff @(posedge clk or posedge reset) begin : wait_and_counters
        if (reset) begin
            r_wait    <= '0;
            r_cause   <= 2'b00;
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            if ((w_next != r_state) || mem_ready)    r_wait <= '0;
            else if (w_mem_wait && (r_wait != WC_MAX)) r_wait <= r_wait + WC_W'(1);
            if ((w_next == S_TRAP) && (r_state != S_TRAP)) r_cause <= w_cause;
            if ((w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP))
                r_retired <= r_retired + CNT_W'(1);
            if (w_mem_wait) r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign state        = r_state;
    assign trap_cause   = r_cause;
    assign retired      = r_retired;
    assign stall_cycles = r_stall;
endmodule

// File: doc/mc_ctrl_fsm_hs.md
Name: mc_ctrl_fsm_hs

Overview:
Multicycle controller for the MIPS-like core: decodes op/funct and sequences a 22-bit datapath control word. It adds wait-state memory handshake, a configurable memory timeout, a trap state for illegal instructions, bus timeouts and interrupts, and retired-instruction and stall counters. It sits between the instruction register and the datapath/memory port.

Parameters:
CNT_W, 32, width of retired/stall counters (wrap modulo 2^CNT_W)
MEM_TIMEOUT, 16, max wait cycles per memory access before bus-error trap; 0 disables timeout
IRQ_EN, 1, 1 enables irq acceptance

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
op_in  in  6  IR[31:26]
funct_in  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
irq  in  1  level interrupt request
state  out  4  current state
ctrl_out  out  22  control word
mem_req  out  1  memory access pending
trap  out  1  trap state active
trap_cause  out  2  01 illegal, 10 bus timeout, 11 irq; held until next trap
epc_write  out  1  capture PC into EPC
retired  out  CNT_W  instructions completed
stall_cycles  out  CNT_W  cycles with mem_req=1 and mem_ready=0

Behaviour:
- Reset (async): state=FETCH(0), wait counter=0, trap_cause=00, counters=0. ctrl_out/mem_req/trap/epc_write are combinational from state and inputs, all 0 except those listed per state.
- ctrl bits: 21 JumpAddr(1=syscall addr); 20:19 PCSrc(00 jta/sca,01 x,10 z,11 ALUout); 18 PCWrite; 17 InstData; 16 MemRead; 15 MemWrite; 14 IRWrite; 13 RegWrite; 12:11 RegDst(00 rt,01 rd,10 r31,11 ri); 10 RegInSrc(1=ALU); 9 DRegSel1; 8 DRegSel0; 7:6 ALUSrcX(00 PC,01 x,10 z); 5:4 ALUSrcY(00 4,01 y,10 imm,11 x4); 3:2 LogicFn; 1:0 FnType(00 arith,01 logic,10 shift,11 compare).
- Legal R funct: ADD 100000, SUB 100001, AND 100100, OR 100101, XOR 100110, NOR 100111, ROT 000000, SLL 000001, SRL 000010, SRA 000011, JR 001000, SYSCALL 001100, SLXOR 101001, SRXOR 101010, DXOR 110010, SLT 111000.
- Legal opcodes: ADDI 001000, SUBI 001001, SLTI 001011, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011.
- FETCH(0): MemRead, mem_req, PCSrc=11, X=PC, Y=4. IRWrite and PCWrite are asserted only in the mem_ready cycle, which goes to DECODE. Otherwise stay.
- Irq: if IRQ_EN, irq=1 and wait counter=0 on FETCH entry cycle, go to TRAP(cause 11) instead of requesting memory; mem_req=0 that cycle.
- DECODE(1): Y=x4.
  - Illegal -> TRAP(01).
  - J: PCWrite -> FETCH. JAL: PCWrite, RegWrite, RegDst=r31, RegInSrc=1 -> FETCH.
  - DXOR -> DX1. LW/SW -> ADDR. BEQ/BNE/JR/SYSCALL -> BRANCH. Other ALU -> EXEC.
- ADDR(2): X=x, Y=imm, FnType arith -> MEMRD(LW) or MEMWR(SW).
- MEMRD(3): InstData, MemRead, mem_req. Wait for mem_ready -> WBLD.
- WBLD(4): RegWrite, MemRead -> FETCH.
- MEMWR(6): InstData, MemWrite, mem_req. Wait for mem_ready -> FETCH.
- BRANCH(5): one cycle -> FETCH.
  - JR: PCSrc=01, PCWrite=1.
  - BEQ/BNE: PCSrc=10, PCWrite=alu_zero / ~alu_zero.
  - SYSCALL: JumpAddr=1, PCSrc=00, PCWrite=1.
- EXEC(7): X=x.
  - Y: y for ROT/R-arith/R-logic/SLT; imm for shifts/SLXOR/SRXOR/I-ALU/SLTI.
  - LogicFn = funct[1:0] (R) or op[1:0] (I); 01 for SLT/SLTI.
  - FnType: logic, shift or compare per class.
  - Next: SHXOR for SLXOR/SRXOR, else WBALU.
- SHXOR(9): X=z, Y=y, logic XOR -> WBALU.
- WBALU(8): RegWrite, RegInSrc=1, RegDst=rd(R) or rt(I) -> FETCH.
- DX1(10): DRegSel=11, X=x, Y=y, logic XOR -> DX2.
- DX2(11): same ALU controls plus RegWrite, RegInSrc=1 -> DXWB.
- DXWB(12): RegWrite, RegDst=ri, RegInSrc=1 -> FETCH.
- TRAP(13): trap=1, epc_write=1, JumpAddr=1, PCSrc=00, PCWrite=1 -> FETCH. trap_cause is registered on entry.
- Timeout: the wait counter increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or state change. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT-1 without ready, go to TRAP(10) next cycle. mem_ready in that same cycle wins.
- retired increments on transitions into FETCH from any state except TRAP/FETCH. stall_cycles increments per stall cycle. Both wrap.
- Reset mid-access aborts immediately; no counter update.

Test Plan:
- ADD R-type, mem_ready=1 always -> states 0,1,7,8,0; WBALU ctrl_out RegWrite=1, RegDst=01, RegInSrc=1; retired=1.
- LW with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; stall_cycles=3; WBLD then FETCH; retired=1.
- MEM_TIMEOUT=4, fetch with mem_ready=0 -> TRAP after 4 wait cycles, trap_cause=10, epc_write=1 one cycle, ctrl_out[21]=1, [18]=1.
- op_in=111111 -> DECODE->TRAP cause 01 -> FETCH; retired unchanged.
- BNE with alu_zero=1 -> BRANCH PCWrite=0; alu_zero=0 -> PCWrite=1, PCSrc=10.
- irq=1 at FETCH entry -> TRAP cause 11, mem_req=0; irq=1 mid-fetch wait -> ignored until next FETCH entry.
